ula_mc: RTL
===========

# ula_mc

Parametrised multi-cycle ALU: the next generation of the single-cycle ULA. It adds a start/busy/done handshake, registered outputs, a signed-overflow flag and iterative multiply/divide into HI/LO registers. It sits in the execute stage of the multi-cycle MIPS datapath, and the control FSM stalls on `busy`. Base operation encodings 0–15 are unchanged from the single-cycle ALU, so decode logic carries over.

## Interface
- `WIDTH`, 32: operand/result width; must be a power of two, ≥ 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  operation request; accepted only when `busy`=0.
- `OP`  in  5  operation code, sampled with `start`.
- `In1`, `In2`  in  WIDTH  operands, sampled with `start`.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; `result` and flags valid and updated.
- `result`  out  WIDTH  registered result; holds until the next `done`.
- `Zero_flag`  out  1  `result`==0, registered with `result`.
- `Overflow_flag`  out  1  signed overflow of op 0/1; 0 for all other ops.
- `div_by_zero`  out  1  set with `done` of op 18/19 when `In2`==0, else 0.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation
- Shift amount is `In1`/`In2` bits [log2(WIDTH)-1:0].
- Single-cycle ops:
  - 0 add, 1 sub, 3 and, 4 nor, 5 or, 6 xor.
  - 7 In2<<In1, 8 In1<<In2.
  - 9 In2>>In1 (logical), 10 In1>>In2 (logical).
  - 12 In2 arithmetic-right In1, 13 In1 arithmetic-right In2. The sign bit is replicated.
  - 14 signed slt, 15 unsigned sltu.
  - 20 mfhi (result=hi), 21 mflo (result=lo).
  - 22 mthi (hi=In1, result=In1), 23 mtlo (lo=In1, result=In1).
  - 2, 11, 24–31: result=0; `done` still pulses.
- Multi-cycle ops:
  - 16 mult, 17 multu: {hi,lo} = full 2·WIDTH product (signed or unsigned), computed by shift-add on magnitudes.
  - 18 div, 19 divu: lo = quotient, hi = remainder, computed by restoring division on magnitudes. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - `result` = new lo on `done`.
- Divide boundary cases:
  - Divide by zero: lo = all ones, hi = In1, `div_by_zero`=1; no trap.
  - Signed −2^(WIDTH−1) / −1: lo = −2^(WIDTH−1), hi = 0.
- `Overflow_flag`: add sets it when both operands share a sign and the sum's sign differs. Sub sets it when the operands' signs differ and the result's sign differs from In1.
- FSM states:
  - IDLE: on `start` with a single-cycle OP, register outputs and stay in IDLE. On OP 16/17, go to MUL. On OP 18/19, go to DIV.
  - MUL / DIV: one iteration per cycle, counter from WIDTH−1 down to 0. Move to FIX when the counter reaches 0.
  - FIX: apply sign correction, write hi/lo/result/flags, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored. No queuing, and operands are not re-sampled.
- Operands are latched internally at accept; `In1`/`In2`/`OP` may change afterwards.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE.
  - `busy`, `done`, `result`, `Zero_flag`=1, `Overflow_flag`, `div_by_zero`, `hi`, `lo` all 0. `Zero_flag` follows result=0.
  - Reset mid-operation aborts it, with no `done`.
- Single-cycle op accepted at edge t: `done`=1 and outputs valid after edge t, for one cycle; `busy` stays 0.
- Multi-cycle op accepted at edge t:
  - `busy`=1 after edge t.
  - After edge t+WIDTH+1: `busy`=0, `done`=1, hi/lo/result updated. Latency is WIDTH+1 cycles.
- Back-to-back:
  - `start` may be asserted in the cycle where `done`=1. It is accepted at the next edge.
  - mfhi/mflo issued then return the new values.
- Outputs not written by an op hold their prior values. Exceptions: `Overflow_flag` and `div_by_zero` are rewritten on every `done`.

## Test plan
- Reset mid-multiply:
  - Stimulus: assert `rst_n`=0 at cycle 10 of an op-16 multiply.
  - Required: next cycle, all outputs 0, `busy`=0, no `done`; `Zero_flag`=1.
- Add overflow (WIDTH=32):
  - Stimulus: op 0, In1=0x7FFFFFFF, In2=1.
  - Required: one cycle later result=0x80000000, `Overflow_flag`=1, `done`=1.
- Signed multiply:
  - Stimulus: op 16, In1=0xFFFFFFFE (−2), In2=3.
  - Required: `done` exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA, result=lo. `start` pulses during `busy` are ignored.
- Signed divide and divide-by-zero:
  - Stimulus: op 18, −7/2.
  - Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: op 19, 5/0.
  - Required: lo=0xFFFFFFFF, hi=5, `div_by_zero`=1.
- Shifts and compares:
  - Stimulus: op 13, In1=0x80000000, In2=0x24.
  - Required: 0xF8000000 (shift amount 4).
  - Stimulus: op 14, −1<1.
  - Required: 1.
  - Stimulus: op 15, 0xFFFFFFFF<1.
  - Required: 0.
- Back-to-back issue:
  - Stimulus: op 23 (mtlo) with In1=0x1234, then mflo on the next cycle.
  - Required: result=0x1234. Repeat the whole suite at WIDTH=8.

Source files
------------

// File: rtl/ula_mc.sv
// ula_mc: multi-cycle ALU with a start/busy/done handshake and registered outputs.
// Multiply is iterative shift-add and divide is restoring division, both into HI/LO.
module ula_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Zero_flag,
    output logic             Overflow_flag,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [SW-1:0]      sh1, sh2;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf;
    logic               is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign result        = result_q;
    assign Zero_flag     = zero_q;
    assign Overflow_flag = ovf_q;
    assign div_by_zero   = dbz_q;
    assign hi            = hi_q;
    assign lo            = lo_q;

    // Single-cycle datapath, evaluated directly on the request inputs.
    always_comb begin
        sh1     = In1[SW-1:0];
        sh2     = In2[SW-1:0];
        sum     = In1 + In2;
        diff    = In1 - In2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (OP)
            5'd0: begin
                alu_res = sum;
                alu_ovf = (In1[WIDTH-1] == In2[WIDTH-1]) && (sum[WIDTH-1] != In1[WIDTH-1]);
            end
            5'd1: begin
                alu_res = diff;
                alu_ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (diff[WIDTH-1] != In1[WIDTH-1]);
            end
            5'd3:  alu_res = In1 & In2;
            5'd4:  alu_res = ~(In1 | In2);
            5'd5:  alu_res = In1 | In2;
            5'd6:  alu_res = In1 ^ In2;
            5'd7:  alu_res = In2 << sh1;
            5'd8:  alu_res = In1 << sh2;
            5'd9:  alu_res = In2 >> sh1;
            5'd10: alu_res = In1 >> sh2;
            5'd12: alu_res = $signed(In2) >>> sh1;
            5'd13: alu_res = $signed(In1) >>> sh2;
            5'd14: alu_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
            5'd15: alu_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
            5'd20: alu_res = hi_q;
            5'd21: alu_res = lo_q;
            5'd22: alu_res = In1;
            5'd23: alu_res = In1;
            default: alu_res = '0;
        endcase
    end

    // Iterative datapath: acc/mq hold {hi,lo} of the product, or {remainder,quotient}.
    always_comb begin
        is_signed = (OP == 5'd16) || (OP == 5'd18);
        a_neg     = is_signed & In1[WIDTH-1];
        b_neg     = is_signed & In2[WIDTH-1];
        a_mag     = a_neg ? -In1 : In1;
        b_mag     = b_neg ? -In2 : In2;
        mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : '0)};
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_sub   = div_shift - {1'b0, opnd_q};
        prod      = {acc_q, mq_q};
        prod_fix  = neg_q ? -prod : prod;
    end

    // Control FSM and next-state for every architectural register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        dvd_d     = dvd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (OP >= 5'd16 && OP <= 5'd19) begin
                        is_div_d  = (OP >= 5'd18);
                        acc_d     = '0;
                        mq_d      = (OP >= 5'd18) ? a_mag : b_mag;
                        opnd_d    = (OP >= 5'd18) ? b_mag : a_mag;
                        dvd_d     = In1;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = (In2 == '0);
                        cnt_d     = '1;
                        state_d   = (OP >= 5'd18) ? S_DIV : S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        dbz_d    = 1'b0;
                        done_d   = 1'b1;
                        if (OP == 5'd22) hi_d = In1;
                        if (OP == 5'd23) lo_d = In1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_sub[WIDTH]) begin
                    acc_d = div_sub[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                // Magnitudes are done; restore signs, divide-by-zero bypasses the array.
                if (is_div_q) begin
                    if (div0_q) begin
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        hi_d = neg_rem_q ? -acc_q : acc_q;
                        lo_d = neg_q ? -mq_q : mq_q;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                result_d = lo_d;
                zero_d   = (lo_d == '0);
                ovf_d    = 1'b0;
                dbz_d    = is_div_q & div0_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            dvd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            dvd_q     <= dvd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule
